rv32i_mem_access: RTL and testbench
===================================

Name: rv32i_mem_access

Overview:
Data-memory access stage directly downstream of the RV32I ALU. It takes the ALU's registered load/store request (word-aligned address, byte enables, pre-shifted store data) and runs it on a pipelined memory-mapped bus with waitrequest/readdatavalid. It holds the pipeline with `stall` until the access completes, then returns raw load data as a 32-bit word for the ALU's byte/halfword extraction. A bus timeout watchdog prevents a dead slave from hanging the core.

Parameters:
TIMEOUT_CYCLES, 256, cycles allowed in REQ+RESP before the access is aborted; 0 disables the watchdog; must be < 65536.
ERR_RDATA, 32'hDEADBEEF, value returned on ld_data when a load times out.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
load  in  1  load request from ALU, held while stall=1
store  in  1  store request from ALU, held while stall=1
addr  in  32  word-aligned byte address (bits[1:0]=0)
st_be  in  4  store byte enables
st_data  in  32  store data, already lane-shifted
ld_data  out  32  load data word, valid in the DONE cycle, held until the next load completes
stall  out  1  pipeline hold (combinational)
bus_error  out  1  one-cycle pulse on timeout abort
avm_address  out  32  bus address
avm_byteenable  out  4  bus byte enables (4'b1111 for loads)
avm_read  out  1  read command
avm_write  out  1  write command
avm_writedata  out  32  write data
avm_waitrequest  in  1  slave not accepting command
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data valid

Behaviour:
- Reset (async, any time including mid-access): state=IDLE, avm_read=avm_write=0, avm_address/byteenable/writedata=0, ld_data=0, bus_error=0, timeout counter=0. An in-flight bus access is abandoned. Any late readdatavalid is ignored.
- States: IDLE, REQ, RESP, DONE (registered FSM).
- IDLE:
  - On load|store, capture addr, st_be (or 4'b1111 for a load), st_data and the op type into the avm_* registers.
  - Assert avm_read or avm_write from the next cycle and go to REQ.
  - If load and store are both high, the store wins and the load is dropped.
- REQ:
  - Command held stable until avm_waitrequest=0 in a cycle, which is the acceptance cycle. The command deasserts the cycle after acceptance.
  - Write accepted -> DONE. Read accepted -> RESP.
- RESP:
  - On avm_readdatavalid=1, register avm_readdata into ld_data and go to DONE.
  - readdatavalid in the REQ acceptance cycle is not a legal response and is ignored.
- DONE:
  - stall=0 for exactly one cycle, then go to IDLE.
  - load/store inputs are ignored in DONE because they still describe the completed op, so no re-issue occurs.
- stall = (IDLE & (load|store)) | REQ | RESP. It is low in DONE and in idle with no request.
- Minimum latencies:
  - Load: issue cycle 0 (IDLE), accept cycle 1, data cycle 2, DONE cycle 3, i.e. stall high for 3 cycles.
  - Store: DONE cycle 2, stall high for 2 cycles.
- Watchdog:
  - The counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES, the FSM drops the command immediately (next edge) and pulses bus_error for 1 cycle.
  - On a load timeout, ld_data=ERR_RDATA; a store timeout leaves ld_data unchanged. The FSM then goes to DONE.
  - Acceptance or readdatavalid in the same cycle as expiry takes precedence over the timeout.
- Outstanding transactions: at most one; no pipelining of commands.

Test Plan:
- Load, zero waits: addr=0x100, slave accepts immediately, readdatavalid next cycle with 0x12345678 -> avm_read high 1 cycle, stall high 3 cycles, ld_data=0x12345678 in DONE.
- Store with 3 waitrequest cycles: addr=0x200, st_be=4'b0100, st_data=0x00AB0000 -> avm_write/address/byteenable/writedata stable for 4 cycles, one write, stall high 5 cycles, no re-issue in DONE.
- Simultaneous load and store at 0x300 -> only a write issued; avm_read never high.
- Timeout with TIMEOUT_CYCLES=8, slave never responds to a load -> command dropped after 8 cycles, bus_error pulses once, ld_data=0xDEADBEEF, FSM returns to IDLE.
- Async reset asserted in RESP -> outputs go to reset values without a clock edge. A later readdatavalid is ignored, and stall=0 until the next request.
- Back-to-back loads (a new load presented the cycle after DONE) -> two separate reads, each with correct ld_data, and no lost or duplicated access.

Source files
------------

// File: rtl/rv32i_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mem_access
// Purpose  : RV32I data-memory access stage. Takes the ALU's load/store
//            request (word-aligned address, byte enables, lane-shifted store
//            data), runs one access on a pipelined memory-mapped bus with
//            waitrequest/readdatavalid, and holds the pipeline with `stall`
//            until the access completes. Raw load data is returned as a full
//            32-bit word. A watchdog aborts an access the slave never
//            finishes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : cycles allowed in REQ+RESP before abort (0 = no watchdog)
//   ERR_RDATA      : word returned on ld_data when a load is aborted
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   load, store         : request from ALU (held while stall=1)
//   addr, st_be, st_data: word address, store byte enables, store data
//   ld_data             : load data, updated when a load completes
//   stall               : pipeline hold (combinational)
//   bus_error           : one-cycle pulse on watchdog abort
//   avm_*               : memory-mapped bus master interface
// ============================================================================
module rv32i_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        bus_error,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter holds the number of REQ/RESP cycles already completed, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
  localparam int unsigned TMO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [15:0] TMO_LAST   = TMO_LAST_I[15:0];
  localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);

  state_t      state;
  state_t      state_next;
  logic [15:0] tmo_cnt;

  logic issue;
  logic accept;
  logic resp_ok;
  logic expire;
  logic abort;

  assign issue   = (state == IDLE) && (load || store);
  assign accept  = (state == REQ)  && !avm_waitrequest;
  // readdatavalid outside RESP (including the acceptance cycle) is ignored.
  assign resp_ok = (state == RESP) && avm_readdatavalid;
  assign expire  = WD_EN && ((state == REQ) || (state == RESP)) && (tmo_cnt == TMO_LAST);
  // A real handshake in the expiry cycle wins over the timeout.
  assign abort   = expire && !accept && !resp_ok;

  assign stall = issue || (state == REQ) || (state == RESP);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) state_next = REQ;
      end
      REQ: begin
        if (accept)     state_next = avm_write ? DONE : RESP;
        else if (abort) state_next = DONE;
      end
      RESP: begin
        if (resp_ok || abort) state_next = DONE;
      end
      DONE: begin
        // Inputs still describe the finished op here; never re-issue.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus command, load data, watchdog and error pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_address    <= 32'd0;
      avm_byteenable <= 4'd0;
      avm_writedata  <= 32'd0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      ld_data        <= 32'd0;
      bus_error      <= 1'b0;
      tmo_cnt        <= 16'd0;
    end else begin
      bus_error <= abort;
      case (state)
        IDLE: begin
          tmo_cnt <= 16'd0;
          if (issue) begin
            avm_address   <= addr;
            avm_writedata <= st_data;
            // Store has priority when both requests are raised.
            if (store) begin
              avm_write      <= 1'b1;
              avm_byteenable <= st_be;
            end else begin
              avm_read       <= 1'b1;
              avm_byteenable <= 4'b1111;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (accept || abort) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
          end
          if (abort && avm_read) ld_data <= ERR_RDATA;
        end
        RESP: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (resp_ok)    ld_data <= avm_readdata;
          else if (abort) ld_data <= ERR_RDATA;
        end
        default: begin
          tmo_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_mem_access
// Purpose  : Directed self-checking bench for rv32i_mem_access with a
//            behavioural bus slave and a load-data scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_access;

  logic        clk;
  logic        reset;
  logic        load;
  logic        store;
  logic [31:0] addr;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        stall;
  logic        bus_error;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  rv32i_mem_access #(
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (32'hDEADBEEF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load             (load),
    .store            (store),
    .addr             (addr),
    .st_be            (st_be),
    .st_data          (st_data),
    .ld_data          (ld_data),
    .stall            (stall),
    .bus_error        (bus_error),
    .avm_address      (avm_address),
    .avm_byteenable   (avm_byteenable),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave configuration (written by the main sequence only)
  int          cfg_waits   = 0;
  bit          cfg_respond = 1'b1;
  logic [31:0] cfg_rdata   = 32'd0;
  int          inject_req  = 0;

  // Slave / monitor state (written by the slave process only)
  int          inject_ack  = 0;
  int          read_cycles = 0;
  int          write_cycles = 0;
  int          reads_acc   = 0;
  int          writes_acc  = 0;
  int          err_pulses  = 0;
  int          unstable    = 0;
  logic [31:0] last_waddr  = 32'd0;
  logic [31:0] last_wdata  = 32'd0;
  logic [3:0]  last_wbe    = 4'd0;
  bit          in_cmd      = 1'b0;
  bit          rd_pending  = 1'b0;
  int          wl          = 0;

  // Behavioural slave: inserts cfg_waits waitrequest cycles per command and
  // returns read data the cycle after acceptance when cfg_respond is set.
  initial begin
    avm_waitrequest   = 1'b1;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0BADF00D;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0BADF00D;
      if (rd_pending) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = cfg_rdata;
        rd_pending        = 1'b0;
      end
      if (inject_ack != inject_req) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = cfg_rdata;
        inject_ack        = inject_req;
      end
      if (bus_error) err_pulses++;
      if (avm_read || avm_write) begin
        if (!in_cmd) begin
          in_cmd = 1'b1;
          wl     = cfg_waits;
        end else if (avm_write && (avm_address !== last_waddr || avm_writedata !== last_wdata
                                   || avm_byteenable !== last_wbe)) begin
          unstable++;
        end
        if (avm_write) begin
          last_waddr = avm_address;
          last_wdata = avm_writedata;
          last_wbe   = avm_byteenable;
          write_cycles++;
        end
        if (avm_read) read_cycles++;
        if (wl > 0) begin
          avm_waitrequest = 1'b1;
          wl--;
        end else begin
          avm_waitrequest = 1'b0;
          if (avm_read) begin
            reads_acc++;
            rd_pending = cfg_respond;
          end else begin
            writes_acc++;
          end
        end
      end else begin
        in_cmd          = 1'b0;
        avm_waitrequest = 1'b1;
      end
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, count stall cycles, and end sampled in the DONE cycle.
  task automatic run_op(input bit ld, input bit st, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        input logic [31:0] rd, input logic [31:0] exp_ld,
                        input int exp_n, input bit keep, input string tag);
    int n;
    logic [31:0] e;
    @(negedge clk);
    load      = ld;
    store     = st;
    addr      = a;
    st_be     = be;
    st_data   = d;
    cfg_rdata = rd;
    if (ld && !st) exp_q.push_back(exp_ld);
    #1;
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall cycles"}, n, exp_n);
    if (ld && !st) begin
      e = exp_q.pop_front();
      check({tag, " ld_data"}, ld_data, e);
    end
    if (!keep) begin
      load  = 1'b0;
      store = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int r0;
    int w0;
    int wa0;
    int e0;
    int u0;

    reset   = 1'b1;
    load    = 1'b0;
    store   = 1'b0;
    addr    = 32'd0;
    st_be   = 4'd0;
    st_data = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst stall",     32'(stall), 32'd0);
    check("rst avm_read",  32'(avm_read), 32'd0);
    check("rst avm_write", 32'(avm_write), 32'd0);
    check("rst address",   avm_address, 32'd0);
    check("rst ld_data",   ld_data, 32'd0);
    check("rst bus_error", 32'(bus_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Load, zero waits
    r0 = read_cycles;
    run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h12345678, 32'h12345678, 3, 1'b0, "load0w");
    check("load0w read cycles", 32'(read_cycles - r0), 32'd1);
    check("load0w address",     avm_address, 32'h100);
    check("load0w byteenable",  32'(avm_byteenable), 32'hF);

    // Store with 3 wait cycles; store held through DONE must not re-issue
    cfg_waits = 3;
    w0  = write_cycles;
    wa0 = writes_acc;
    u0  = unstable;
    run_op(1'b0, 1'b1, 32'h200, 4'b0100, 32'h00AB0000, 32'h0, 32'h0, 5, 1'b1, "store3w");
    @(negedge clk);
    store = 1'b0;
    #1;
    check("store3w no reissue write", 32'(avm_write), 32'd0);
    check("store3w stall after",      32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("store3w write cycles", 32'(write_cycles - w0), 32'd4);
    check("store3w writes acc",   32'(writes_acc - wa0), 32'd1);
    check("store3w stable",       32'(unstable - u0), 32'd0);
    check("store3w address",      last_waddr, 32'h200);
    check("store3w byteenable",   32'(last_wbe), 32'h4);
    check("store3w writedata",    last_wdata, 32'h00AB0000);
    cfg_waits = 0;

    // Simultaneous load and store: store wins
    r0  = read_cycles;
    wa0 = writes_acc;
    run_op(1'b1, 1'b1, 32'h300, 4'b0011, 32'h00001111, 32'h0, 32'h0, 2, 1'b0, "ldst");
    @(negedge clk);
    #1;
    check("ldst read cycles", 32'(read_cycles - r0), 32'd0);
    check("ldst writes acc",  32'(writes_acc - wa0), 32'd1);
    check("ldst address",     last_waddr, 32'h300);

    // Back-to-back loads
    r0 = reads_acc;
    run_op(1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 32'hA5A50001, 32'hA5A50001, 3, 1'b1, "b2b first");
    run_op(1'b1, 1'b0, 32'h404, 4'h0, 32'h0, 32'h5A5A0002, 32'h5A5A0002, 3, 1'b0, "b2b second");
    @(negedge clk);
    #1;
    check("b2b reads acc", 32'(reads_acc - r0), 32'd2);
    check("b2b address",   avm_address, 32'h404);

    // Load timeout with a silent slave
    cfg_waits = 1000;
    r0 = read_cycles;
    e0 = err_pulses;
    run_op(1'b1, 1'b0, 32'h500, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 9, 1'b0, "ld tmo");
    check("ld tmo bus_error in DONE", 32'(bus_error), 32'd1);
    check("ld tmo avm_read dropped",  32'(avm_read), 32'd0);
    @(negedge clk);
    #1;
    check("ld tmo bus_error after", 32'(bus_error), 32'd0);
    check("ld tmo stall after",     32'(stall), 32'd0);
    check("ld tmo read cycles",     32'(read_cycles - r0), 32'd8);
    check("ld tmo error pulses",    32'(err_pulses - e0), 32'd1);

    // Store timeout leaves ld_data unchanged
    run_op(1'b0, 1'b1, 32'h600, 4'hF, 32'h77777777, 32'h0, 32'h0, 9, 1'b0, "st tmo");
    check("st tmo bus_error", 32'(bus_error), 32'd1);
    check("st tmo ld_data",   ld_data, 32'hDEADBEEF);
    cfg_waits = 0;

    // Asynchronous reset while waiting in RESP
    cfg_respond = 1'b0;
    @(negedge clk);
    load = 1'b1;
    addr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstresp in RESP stall", 32'(stall), 32'd1);
    #1;
    reset = 1'b1;
    load  = 1'b0;
    #1;
    check("rstresp avm_read",   32'(avm_read), 32'd0);
    check("rstresp address",    avm_address, 32'd0);
    check("rstresp byteenable", 32'(avm_byteenable), 32'd0);
    check("rstresp ld_data",    ld_data, 32'd0);
    check("rstresp stall",      32'(stall), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    cfg_rdata = 32'hCAFEF00D;
    inject_req++;
    repeat (3) @(negedge clk);
    #1;
    check("rstresp late rdv ld_data", ld_data, 32'd0);
    check("rstresp late rdv stall",   32'(stall), 32'd0);
    cfg_respond = 1'b1;

    // Recovery after reset
    run_op(1'b1, 1'b0, 32'h800, 4'h0, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0F, 3, 1'b0, "recover");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
